// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module : pwm_pkg
// Brief  : Shared constants, state encoding and clamp helper for pwm_frame_gen.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

  localparam int unsigned PULSE_W  = 12;
  localparam int unsigned US_CNT_W = 15;

  localparam logic [PULSE_W-1:0] PWM_MIN_US  = 12'd900;
  localparam logic [PULSE_W-1:0] PWM_MAX_US  = 12'd2000;
  localparam logic [PULSE_W-1:0] PWM_IDLE_US = 12'd900;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  function automatic logic [PULSE_W-1:0] pwm_clamp(input logic [PULSE_W-1:0] us);
    if (us < PWM_MIN_US) begin
      return PWM_MIN_US;
    end
    if (us > PWM_MAX_US) begin
      return PWM_MAX_US;
    end
    return us;
  endfunction

endpackage

`default_nettype wire

// File: rtl/us_tick_gen.sv
//------------------------------------------------------------------------------
// Module : us_tick_gen
// Brief  : Microsecond prescaler; one-cycle tick every CLK_PER_US clocks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module us_tick_gen #(
  parameter int CLK_PER_US = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_US - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || (count_q == CNT_LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = !clear && (count_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_frame_gen.sv
//------------------------------------------------------------------------------
// Module : pwm_frame_gen
// Brief  : ESC servo PWM frame generator, width latched once per frame.
//          Define PWM_CLAMP_EN to clamp the latched width to 900..2000 us.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_frame_gen
  import pwm_pkg::*;
#(
  parameter int CLK_PER_US = 27,
  parameter int FRAME_US   = 20000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [PULSE_W-1:0] pulse_time,
  output logic               pwm_out,
  output logic               frame_start,
  output logic [PULSE_W-1:0] pulse_latched
);

  localparam logic [US_CNT_W-1:0] US_LAST = US_CNT_W'(FRAME_US - 1);

  pwm_state_e          state_q, state_d;
  logic [US_CNT_W-1:0] us_cnt_q, us_cnt_d;
  logic [PULSE_W-1:0]  latched_q, latched_d;
  logic                pwm_q, pwm_d;
  logic                fs_q, fs_d;

  logic                w_tick;
  logic                w_clear;
  logic                w_frame_end;
  logic                w_frame_go;
  logic [US_CNT_W-1:0] w_us_next;
  logic [PULSE_W-1:0]  w_pulse_sel;

`ifdef PWM_CLAMP_EN
  assign w_pulse_sel = pwm_clamp(pulse_time);
`else
  assign w_pulse_sel = pulse_time;
`endif

  assign w_clear     = (state_q == ST_IDLE);
  assign w_frame_end = (us_cnt_q == US_LAST);
  assign w_us_next   = us_cnt_q + US_CNT_W'(1);

  us_tick_gen #(
    .CLK_PER_US (CLK_PER_US)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_comb begin
    state_d    = state_q;
    us_cnt_d   = us_cnt_q;
    latched_d  = latched_q;
    fs_d       = 1'b0;
    w_frame_go = 1'b0;

    if ((state_q != ST_IDLE) && w_tick) begin
      us_cnt_d = w_frame_end ? '0 : w_us_next;
    end

    case (state_q)
      ST_IDLE: begin
        us_cnt_d   = '0;
        w_frame_go = enable;
      end
      ST_HIGH: begin
        if (w_tick && (w_us_next == US_CNT_W'(latched_q))) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_tick && w_frame_end) begin
          if (enable) begin
            w_frame_go = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero-width frame skips HIGH so the line never glitches high.
    if (w_frame_go) begin
      latched_d = w_pulse_sel;
      fs_d      = 1'b1;
      state_d   = (w_pulse_sel == '0) ? ST_LOW : ST_HIGH;
    end

    pwm_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      us_cnt_q  <= '0;
      latched_q <= '0;
      pwm_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      us_cnt_q  <= us_cnt_d;
      latched_q <= latched_d;
      pwm_q     <= pwm_d;
      fs_q      <= fs_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign frame_start   = fs_q;
  assign pulse_latched = latched_q;

endmodule

`default_nettype wire

// File: doc/pwm_frame_gen.md
PWM_FRAME_GEN -- requirements
Module: pwm_frame_gen

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 27, meaning clock cycles per microsecond (≥2).
REQ-002 SHALL have parameter FRAME_US, default 20000, meaning frame period in µs (50 Hz); legal range 4097..32767.
REQ-003 SHALL have port clock, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1, meaning a high level allows frames to be generated.
REQ-006 SHALL have port pulse_time, input, 12, meaning the requested ESC pulse width in µs (throttle-to-PWM stage output, 900 = idle).
REQ-007 SHALL have port pwm_out, output, 1, meaning the registered ESC servo pulse line.
REQ-008 SHALL have port frame_start, output, 1, meaning a one-cycle strobe at the first clock of each frame.
REQ-009 SHALL have port pulse_latched, output, 12, meaning the width in µs applied to the current frame.

Function
REQ-010 SHALL generate a µs tick: prescaler counts 0..CLK_PER_US-1, wraps, tick high one cycle when count = CLK_PER_US-1.
REQ-011 SHALL keep a 15-bit µs counter us_cnt, 0..FRAME_US-1, incremented on tick, wrapping to 0 after FRAME_US-1.
REQ-012 SHALL implement states IDLE, HIGH, LOW; pwm_out = 1 only in HIGH.
REQ-013 IDLE: prescaler and us_cnt held at 0, pwm_out 0; enable sampled high -> frame start on next clock.
REQ-014 Frame start (from IDLE, or on the tick where us_cnt = FRAME_US-1 in LOW with enable high): latch pulse_time into pulse_latched, pulse frame_start one cycle, enter HIGH (LOW if latched width = 0), same clock edge.
REQ-015 HIGH -> LOW on the tick where us_cnt+1 = pulse_latched; pulse high time SHALL be exactly pulse_latched*CLK_PER_US clocks.
REQ-016 LOW at frame end with enable low -> IDLE; frame period SHALL be exactly FRAME_US*CLK_PER_US clocks.
REQ-017 enable deasserted mid-frame SHALL NOT truncate the pulse or frame; the current frame completes first.
REQ-018 pulse_time changes mid-frame SHALL NOT affect the current frame (glitch-free, latched once per frame).
REQ-019 pulse_latched = 0 SHALL produce no pulse; frame_start still pulses.

Reset
REQ-020 reset high SHALL immediately force state IDLE, pwm_out 0, frame_start 0, pulse_latched 0, prescaler 0, us_cnt 0.
REQ-021 reset mid-pulse SHALL drop pwm_out the same instant; after release, first frame begins per REQ-013.

Configuration
REQ-022 Macro PWM_CLAMP_EN defined: value latched SHALL be clamped to PWM_MIN_US (900) .. PWM_MAX_US (2000).
REQ-023 PWM_CLAMP_EN undefined: pulse_time SHALL be latched unmodified (0 gives no pulse, 4095 gives 4095 µs).

Structure
REQ-024 Shared package pwm_pkg SHALL hold PWM_MIN_US, PWM_MAX_US, PWM_IDLE_US (900) and the state encoding.
REQ-025 Prescaler SHALL be sub-module us_tick_gen (ports clock, reset, clear, tick; parameter CLK_PER_US).

Verification (CLK_PER_US=4, FRAME_US=5000)
REQ-026 enable=1, pulse_time=1500 -> pwm_out high 6000 clocks, period 20000 clocks, frame_start once per period.
REQ-027 pulse_time 1500->1864 at clock 3000 of a frame -> that frame 6000 clocks high, next frame 7456.
REQ-028 enable dropped at clock 100 of a frame -> full 6000-clock pulse, frame ends at 20000, then pwm_out 0 and no frame_start.
REQ-029 reset asserted during HIGH -> pwm_out 0 without a clock edge; release with enable=1 -> frame_start on next clock.
REQ-030 pulse_time=0: with PWM_CLAMP_EN -> 3600 clocks high; without -> pwm_out stays 0, frame_start still every 20000.
REQ-031 pulse_time=4095 without PWM_CLAMP_EN -> 16380 clocks high; with it -> 8000 clocks high.
